rns_dot_sequencer: RTL

Multi-cycle controller that sequences the 4-lane RNS multiply and add datapath to compute a dot product of `len` operand pairs, with each operand already in residue form. It sits between the int-to-RNS converter output stream and the RNS-to-int converter input. Operands arrive over a valid/ready stream at one term per cycle, pass through a registered per-lane multiply stage and a per-lane modular accumulator, and leave as a single 32-bit RNS word on a valid/ready output.

---
 rtl/rns_dot_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rns_dot_sequencer.sv
// rns_dot_sequencer: 4-lane RNS multiply-accumulate dot-product controller.
// Optional lane-range error flag built when RNS_DOT_RANGE_CHECK_EN is defined.
module rns_dot_sequencer #(
   parameter int unsigned B0 = 256,
   parameter int unsigned B1 = 255,
   parameter int unsigned B2 = 253,
   parameter int unsigned B3 = 251
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  len,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

   state_t      state_q;
   logic [7:0]  len_q;
   logic [7:0]  cnt_q;
   logic [31:0] p_q;
   logic [31:0] acc_q;
   logic        p_valid_q;
   logic [31:0] p_d;
   logic [31:0] acc_d;
   logic        hs;

`ifdef RNS_DOT_RANGE_CHECK_EN
   logic [3:0]  oor;
   logic        err_q;
`endif

   assign hs = in_valid & in_ready;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      localparam logic [15:0] M = (g == 0) ? 16'(B0) :
                                  (g == 1) ? 16'(B1) :
                                  (g == 2) ? 16'(B2) : 16'(B3);
      logic [15:0] prod;
      logic [8:0]  sum;

      assign prod = {8'd0, x1[8*g +: 8]} * {8'd0, x2[8*g +: 8]};
      assign sum  = {1'b0, acc_q[8*g +: 8]} + {1'b0, p_q[8*g +: 8]};
      assign p_d[8*g +: 8]   = 8'(prod % M);
      assign acc_d[8*g +: 8] = 8'(sum % 9'(M));

`ifdef RNS_DOT_RANGE_CHECK_EN
      assign oor[g] = ({1'b0, x1[8*g +: 8]} >= 9'(M)) |
                      ({1'b0, x2[8*g +: 8]} >= 9'(M));
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_q     <= 8'd0;
         cnt_q     <= 8'd0;
         p_q       <= 32'd0;
         acc_q     <= 32'd0;
         p_valid_q <= 1'b0;
`ifdef RNS_DOT_RANGE_CHECK_EN
         err_q     <= 1'b0;
`endif
      end else begin
         // accumulate stage trails the product register by one edge
         if (p_valid_q) acc_q <= acc_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  acc_q     <= 32'd0;
                  cnt_q     <= 8'd0;
                  p_valid_q <= 1'b0;
                  len_q     <= len;
`ifdef RNS_DOT_RANGE_CHECK_EN
                  err_q     <= 1'b0;
`endif
                  state_q   <= (len == 8'd0) ? OUT : ACC;
               end
            end
            ACC: begin
               if (hs) begin
                  p_q       <= p_d;
                  p_valid_q <= 1'b1;
                  cnt_q     <= cnt_q + 8'd1;
`ifdef RNS_DOT_RANGE_CHECK_EN
                  if (|oor) err_q <= 1'b1;
`endif
                  if (cnt_q == len_q - 8'd1) state_q <= DRAIN;
               end else begin
                  p_valid_q <= 1'b0;
               end
            end
            DRAIN: begin
               p_valid_q <= 1'b0;
               state_q   <= OUT;
            end
            OUT: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ACC);
   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign y         = acc_q;

`ifdef RNS_DOT_RANGE_CHECK_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule
